// File: rtl/vsd_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : vsd_multi_timer
// Purpose  : NUM_CH independent down-counting timers behind one memory-mapped
//            slave port. Each channel supports one-shot/periodic operation,
//            an optional prescaler, sticky timeout/overrun flags and a
//            software restart. Masked per-channel IRQs are ORed to irq_any.
// Ports    : clk, resetn (async, active-low)
//            sel, we, addr[7:0], wdata[31:0]  - slave write/read request
//            rdata[31:0]                      - combinational read data
//            irq[NUM_CH-1:0], irq_any         - interrupt outputs
// Revision : 1.0 - initial release
// ============================================================================
module vsd_multi_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sel,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic              w_wr;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] w_tflag;
  logic [31:0]       w_rd_ch [NUM_CH];

  assign w_wr = sel && we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mask <= '0;
    end else if (w_wr && (addr == 8'hF4)) begin
      r_mask <= wdata[NUM_CH-1:0];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] c_idx = 4'(i);

    logic               r_en;
    logic               r_mode;
    logic               r_presc_en;
    logic [PRESC_W-1:0] r_div;
    logic [PRESC_W-1:0] r_pcnt;
    logic [CNT_W-1:0]   r_load;
    logic [CNT_W-1:0]   r_value;
    logic               r_tflag;
    logic               r_ovr;
    logic               r_ld;      // load cycle pending (follows en rise / restart)

    logic               w_hit;
    logic               w_ctrl_wr;
    logic               w_load_wr;
    logic               w_stat_wr;
    logic               w_start;
    logic               w_tick;
    logic               w_ev;
    logic               w_to;
    logic [31:0]        w_rd;

    assign w_hit     = (addr[7:4] == c_idx);
    assign w_ctrl_wr = w_wr && w_hit && (addr[3:0] == 4'h0);
    assign w_load_wr = w_wr && w_hit && (addr[3:0] == 4'h4);
    assign w_stat_wr = w_wr && w_hit && (addr[3:0] == 4'hC);
    // A load is armed by an en 0->1 write, or by restart written with en=1.
    // Restart written together with en=0 is simply dropped.
    assign w_start   = w_ctrl_wr && wdata[0] && (!r_en || wdata[3]);
    assign w_tick    = r_presc_en ? (r_pcnt == r_div) : 1'b1;
    assign w_ev      = r_en && !r_ld && w_tick;
    assign w_to      = w_ev && (r_value <= CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_en       <= 1'b0;
        r_mode     <= 1'b0;
        r_presc_en <= 1'b0;
        r_div      <= '0;
        r_pcnt     <= '0;
        r_load     <= '0;
        r_value    <= '0;
        r_tflag    <= 1'b0;
        r_ovr      <= 1'b0;
        r_ld       <= 1'b0;
      end else begin
        r_ld <= w_start;

        if (!r_en || !r_presc_en || r_ld || w_start) begin
          r_pcnt <= '0;
        end else if (r_pcnt == r_div) begin
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + PRESC_W'(1);
        end

        if (r_ld) begin
          r_value <= r_load;
        end else if (w_ev) begin
          if (w_to) begin
            r_value <= r_mode ? r_load : '0;
          end else begin
            r_value <= r_value - CNT_W'(1);
          end
        end

        // Software CTRL write takes priority over the one-shot auto-clear.
        if (w_ctrl_wr) begin
          r_en       <= wdata[0];
          r_mode     <= wdata[1];
          r_presc_en <= wdata[2];
          r_div      <= wdata[8 +: PRESC_W];
        end else if (w_to && !r_mode) begin
          r_en <= 1'b0;
        end

        if (w_load_wr) begin
          r_load <= wdata[CNT_W-1:0];
        end

        // Hardware set beats the W1C clear in the same cycle.
        if (w_to) begin
          r_tflag <= 1'b1;
        end else if (w_stat_wr && wdata[0]) begin
          r_tflag <= 1'b0;
        end

        if (w_to && r_tflag) begin
          r_ovr <= 1'b1;
        end else if (w_stat_wr && wdata[1]) begin
          r_ovr <= 1'b0;
        end
      end
    end

    always_comb begin
      w_rd = '0;
      if (w_hit) begin
        case (addr[3:0])
          4'h0:    w_rd = 32'({r_div, 5'b00000, r_presc_en, r_mode, r_en});
          4'h4:    w_rd = 32'(r_load);
          4'h8:    w_rd = 32'(r_value);
          4'hC:    w_rd = 32'({r_ovr, r_tflag});
          default: w_rd = '0;
        endcase
      end
    end

    assign w_rd_ch[i] = w_rd;
    assign w_tflag[i] = r_tflag;
  end

  always_comb begin
    rdata = '0;
    if (addr == 8'hF0) begin
      rdata = 32'(w_tflag);
    end else if (addr == 8'hF4) begin
      rdata = 32'(r_mask);
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        rdata = rdata | w_rd_ch[k];
      end
    end
  end

  assign irq     = w_tflag & r_mask;
  assign irq_any = |irq;

endmodule
`default_nettype wire

// File: tb/tb_vsd_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vsd_multi_timer
// Purpose  : Scoreboard bench for vsd_multi_timer. Directed scenarios push
//            spec-derived constants; a randomized phase pushes values from a
//            behavioural per-clock reference model. A negedge monitor pops and
//            compares rdata/irq/irq_any whenever a read is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vsd_multi_timer;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PRESC_W = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              sel = 1'b0;
  logic              we = 1'b0;
  logic [7:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  always #5 clk = ~clk;

  vsd_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  typedef struct {
    logic [7:0]        a;
    logic [31:0]       d;
    logic [NUM_CH-1:0] i;
    string             nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sel && !we) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read addr=%h rdata=%h (no expectation queued)", addr, rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.d || irq !== e.i || irq_any !== (|e.i) || addr !== e.a) begin
          n_fail++;
          $display("FAIL %s addr=%h rdata=%h required=%h irq=%b required=%b irq_any=%b",
                   e.nm, addr, rdata, e.d, irq, e.i, irq_any);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic               m_en    [NUM_CH];
  logic               m_mode  [NUM_CH];
  logic               m_pen   [NUM_CH];
  logic [PRESC_W-1:0] m_div   [NUM_CH];
  logic [PRESC_W-1:0] m_pcnt  [NUM_CH];
  logic [CNT_W-1:0]   m_load  [NUM_CH];
  logic [CNT_W-1:0]   m_value [NUM_CH];
  logic               m_tf    [NUM_CH];
  logic               m_ov    [NUM_CH];
  logic               m_pend  [NUM_CH];
  logic [NUM_CH-1:0]  m_mask;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_pen[c] = 0; m_div[c] = 0; m_pcnt[c] = 0;
      m_load[c] = 0; m_value[c] = 0; m_tf[c] = 0; m_ov[c] = 0; m_pend[c] = 0;
    end
    m_mask = '0;
  endtask

  function automatic logic [NUM_CH-1:0] model_irq();
    logic [NUM_CH-1:0] f;
    for (int c = 0; c < NUM_CH; c++) f[c] = m_tf[c];
    return f & m_mask;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int ch;
    logic [NUM_CH-1:0] f;
    ch = int'(a[7:4]);
    for (int c = 0; c < NUM_CH; c++) f[c] = m_tf[c];
    if (a == 8'hF0) return 32'(f);
    if (a == 8'hF4) return 32'(m_mask);
    if (ch >= NUM_CH) return 32'd0;
    case (a[3:0])
      4'h0: return (32'(m_div[ch]) << 8) + (32'(m_pen[ch]) << 2) + (32'(m_mode[ch]) << 1) + 32'(m_en[ch]);
      4'h4: return 32'(m_load[ch]);
      4'h8: return 32'(m_value[ch]);
      4'hC: return (32'(m_ov[ch]) << 1) + 32'(m_tf[ch]);
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the spec rules, using the inputs present at that edge.
  task automatic model_step();
    logic wr_c, wr_l, wr_s, start, tick, count, tmo;
    logic [CNT_W-1:0] nv;
    if (!resetn) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      wr_c  = sel && we && (int'(addr[7:4]) == c) && (addr[3:0] == 4'h0);
      wr_l  = sel && we && (int'(addr[7:4]) == c) && (addr[3:0] == 4'h4);
      wr_s  = sel && we && (int'(addr[7:4]) == c) && (addr[3:0] == 4'hC);
      start = wr_c && wdata[0] && (!m_en[c] || wdata[3]);
      tick  = m_pen[c] ? (m_pcnt[c] == m_div[c]) : 1'b1;
      count = m_en[c] && !m_pend[c] && tick;
      tmo   = count && (m_value[c] <= 1);
      nv = m_value[c];
      if (m_pend[c]) nv = m_load[c];
      else if (tmo) nv = m_mode[c] ? m_load[c] : '0;
      else if (count) nv = m_value[c] - 1;
      if (!m_en[c] || !m_pen[c] || m_pend[c] || start) m_pcnt[c] = 0;
      else m_pcnt[c] = (m_pcnt[c] == m_div[c]) ? '0 : m_pcnt[c] + 1'b1;
      m_value[c] = nv;
      if (tmo && m_tf[c]) m_ov[c] = 1;
      else if (wr_s && wdata[1]) m_ov[c] = 0;
      if (tmo) m_tf[c] = 1;
      else if (wr_s && wdata[0]) m_tf[c] = 0;
      if (wr_c) begin
        m_en[c] = wdata[0]; m_mode[c] = wdata[1]; m_pen[c] = wdata[2];
        m_div[c] = wdata[8 +: PRESC_W];
      end else if (tmo && !m_mode[c]) begin
        m_en[c] = 0;
      end
      if (wr_l) m_load[c] = wdata[CNT_W-1:0];
      m_pend[c] = start;
    end
    if (sel && we && addr == 8'hF4) m_mask = wdata[NUM_CH-1:0];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    cycle();
    sel = 0; we = 0;
  endtask

  task automatic rd_exp(input logic [7:0] a, input logic [31:0] d,
                        input logic [NUM_CH-1:0] i, input string nm);
    exp_t e;
    e.a = a; e.d = d; e.i = i; e.nm = nm;
    sel = 1; we = 0; addr = a;
    sb.push_back(e);
    cycle();
    sel = 0;
  endtask

  task automatic rd_model(input logic [7:0] a, input string nm);
    rd_exp(a, model_read(a), model_irq(), nm);
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    case ($urandom_range(0, 9))
      0:       a = 8'hF0;
      1:       a = 8'hF4;
      2:       a = 8'hF8;
      default: a = {4'($urandom_range(0, NUM_CH)), 2'($urandom_range(0, 3)), 2'b00};
    endcase
    return a;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    model_reset();
    resetn = 0;
    idle(2);
    resetn = 1;

    // reset state
    rd_exp(8'h00, 0, 0, "rst_ctrl0");
    rd_exp(8'h04, 0, 0, "rst_load0");
    rd_exp(8'h38, 0, 0, "rst_value3");
    rd_exp(8'h0C, 0, 0, "rst_status0");
    rd_exp(8'hF0, 0, 0, "rst_irqstat");
    rd_exp(8'hF4, 0, 0, "rst_mask");

    // ch0 periodic LOAD=5
    wr(8'h04, 5);
    wr(8'h00, 32'h3);
    idle(1);
    for (int k = 0; k < 6; k++) rd_exp(8'h08, (k < 5) ? 32'(5 - k) : 32'd5, 0, "ch0_value_seq");
    rd_exp(8'h0C, 32'h1, 0, "ch0_first_timeout");
    idle(3);
    rd_exp(8'h0C, 32'h3, 0, "ch0_overrun");
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'h3);
    rd_exp(8'h0C, 32'h0, 0, "ch0_w1c");
    rd_exp(8'h08, 32'd3, 0, "ch0_value_held");

    // ch1 one-shot LOAD=3
    wr(8'h14, 3);
    wr(8'h10, 32'h1);
    idle(4);
    rd_exp(8'h10, 32'h0, 0, "ch1_en_autoclear");
    rd_exp(8'h18, 32'h0, 0, "ch1_value_zero");
    idle(5);
    rd_exp(8'h1C, 32'h1, 0, "ch1_no_more_events");
    wr(8'hF4, 32'h2);
    rd_exp(8'hF0, 32'h2, 4'h2, "ch1_irq_on");
    wr(8'h1C, 32'h1);
    rd_exp(8'h1C, 32'h0, 4'h0, "ch1_irq_cleared");

    // ch2 prescaled LOAD=2 div=4
    wr(8'h24, 2);
    wr(8'h20, 32'h0405);
    idle(1);
    rd_exp(8'h28, 32'd2, 0, "ch2_loaded");
    idle(3);
    rd_exp(8'h28, 32'd2, 0, "ch2_before_tick");
    rd_exp(8'h28, 32'd1, 0, "ch2_first_tick");
    idle(3);
    rd_exp(8'h2C, 32'h0, 0, "ch2_before_timeout");
    rd_exp(8'h2C, 32'h1, 0, "ch2_timeout");
    wr(8'h20, 32'h0);
    wr(8'h2C, 32'h1);

    // timeout coinciding with W1C: set wins
    wr(8'h34, 3);
    wr(8'h30, 32'h3);
    idle(3);
    wr(8'h3C, 32'h1);
    rd_exp(8'h3C, 32'h1, 0, "ch3_set_beats_w1c");
    wr(8'h30, 32'h0);
    wr(8'h3C, 32'h3);

    // CTRL en=0 written on the one-shot expiry edge
    wr(8'h34, 2);
    wr(8'h30, 32'h1);
    idle(2);
    wr(8'h30, 32'h0);
    rd_exp(8'h30, 32'h0, 0, "ch3_sw_ctrl_expiry");
    rd_exp(8'h38, 32'h0, 0, "ch3_value_expiry");
    rd_exp(8'h3C, 32'h1, 0, "ch3_flag_expiry");
    wr(8'h3C, 32'h1);

    // mid-count restart with LOAD=7
    wr(8'h04, 7);
    wr(8'h00, 32'h3);
    idle(6);
    rd_exp(8'h08, 32'd2, 0, "restart_pre_value");
    wr(8'h00, 32'hB);
    idle(1);
    rd_exp(8'h08, 32'd7, 0, "restart_reload");
    rd_exp(8'h08, 32'd6, 0, "restart_count_on");
    rd_exp(8'h00, 32'h3, 0, "restart_reads_zero");

    // async reset mid-count; mask is 0x2 and ch0 counting beforehand
    resetn = 0;
    model_reset();
    rd_exp(8'h08, 0, 0, "areset_value");
    rd_exp(8'h00, 0, 0, "areset_ctrl");
    rd_exp(8'hF4, 0, 0, "areset_mask");
    resetn = 1;

    // unmapped reads and writes
    rd_exp(8'h40, 0, 0, "unmapped_ch4_read");
    rd_exp(8'hF8, 0, 0, "unmapped_f8_read");
    wr(8'h40, 32'hFFFF_FFFF);
    wr(8'h44, 32'd9);
    wr(8'hF8, 32'hFF);
    wr(8'h02, 32'h3);
    wr(8'h54, 32'd9);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_exp(8'(c * 16 + 0), 0, 0, "unmapped_no_effect_ctrl");
      rd_exp(8'(c * 16 + 4), 0, 0, "unmapped_no_effect_load");
    end
    rd_exp(8'hF4, 0, 0, "unmapped_no_effect_mask");

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) < 5) begin
        a = rand_addr();
        rd_model(a, "rand_read");
      end else begin
        a = rand_addr();
        case (a[3:0])
          4'h0:    d = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 15));
          4'h4:    d = 32'($urandom_range(0, 6));
          default: d = $urandom;
        endcase
        wr(a, d);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int o = 0; o < 4; o++) rd_model(8'(c * 16 + o * 4), "final_sweep");
    end
    rd_model(8'hF0, "final_irqstat");

    idle(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vsd_multi_timer.md
Name: vsd_multi_timer

Overview:
Parametrised multi-channel successor to the single-channel SoC timer. It provides NUM_CH independent down-counters behind one memory-mapped slave port. Each channel has one-shot or periodic mode, a prescaler, sticky timeout and overrun flags, and a software restart. Per-channel IRQs are masked and ORed into one line for the SoC interrupt controller.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/LOAD/VALUE width in bits (8..32)
PRESC_W, 8, prescaler divider width in bits (1..8)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
sel  input  1  slave select
we  input  1  write enable; a write occurs on the clk edge when sel&&we
addr  input  8  byte address; [7:4]=channel index or 0xF for global, [3:0]=register offset
wdata  input  32  write data
rdata  output  32  combinational read data; 0 for unmapped/nonexistent channels
irq  output  NUM_CH  per-channel interrupt: timeout_flag & IRQ_MASK bit
irq_any  output  1  OR of irq

Behaviour:
- Reset is asynchronous, active-low, on clk. All registers reset to 0; irq=0 and irq_any=0.
- Per-channel map, ch=addr[7:4]<NUM_CH:
  - 0x0 CTRL: [0]en, [1]mode (1=periodic), [2]presc_en, [3]restart (write-only, self-clearing, reads 0), [8+PRESC_W-1:8]presc_div.
  - 0x4 LOAD: CNT_W bits, rw.
  - 0x8 VALUE: ro.
  - 0xC STATUS: [0]timeout_flag, [1]overrun; both W1C.
- Global registers:
  - 0xF0 IRQ_STATUS: ro, {0, timeout_flag[NUM_CH-1:0]}.
  - 0xF4 IRQ_MASK: rw, NUM_CH bits.
- Register widths: writes are truncated to the field width; reads are zero-extended. Writes to unmapped addresses are ignored.
- Prescaler, per channel:
  - presc_cnt is PRESC_W bits.
  - tick = presc_en ? (presc_cnt==presc_div) : 1.
  - presc_cnt counts 0..presc_div and then wraps, so the tick period is presc_div+1 clocks.
  - presc_cnt is held at 0 whenever en=0, presc_en=0, on an en rising edge, or on restart.
- Load: on the cycle after en rises 0->1, or after a restart write with en=1, VALUE<=LOAD and presc_cnt<=0. No decrement occurs that cycle.
- Count, each tick while en=1 and not loading:
  - VALUE>1: VALUE<=VALUE-1.
  - VALUE<=1: timeout event.
    - timeout_flag<=1.
    - If timeout_flag was already 1, overrun<=1.
    - Periodic mode: VALUE<=LOAD.
    - One-shot mode: VALUE<=0 and hardware clears CTRL.en.
- Timeout period: LOAD ticks; LOAD=0 behaves as LOAD=1, i.e. a timeout every tick.
- en=0: VALUE holds its value, and no events occur.
- Simultaneous events:
  - Timeout set and STATUS W1C in the same cycle: set wins; the flag stays 1.
  - One-shot en auto-clear and a software CTRL write in the same cycle: the software write wins.
  - LOAD write during counting: takes effect at the next reload or load only.
  - Restart written together with en=0: no load occurs; restart is discarded.
- Channels are fully independent. A write only affects the addressed channel.
- IRQ outputs are registered-flag driven. irq rises on the cycle after the timeout tick edge and stays high until W1C or mask clear.

Test Plan:
- Ch0 LOAD=5, CTRL=0x3 (periodic, no prescaler) -> VALUE reads 5,4,3,2,1, then reload to 5; timeout_flag set every 5 clocks; overrun=1 at the 2nd timeout if the flag is not cleared.
- Ch1 LOAD=3, CTRL=0x1 (one-shot) -> timeout after 3 clocks; VALUE=0; CTRL.en reads 0; no further events; IRQ_MASK=0x2 -> irq[1]=1, irq_any=1; STATUS write 0x1 -> irq[1]=0.
- Ch2 LOAD=2, CTRL=0x0405 (presc_en, div=4) -> VALUE decrements every 5 clocks; timeout 10 clocks after load.
- Timeout tick coinciding with STATUS W1C -> flag remains 1; separately, CTRL write en=0 on the one-shot expiry cycle -> en=0, VALUE=0, flag=1.
- Mid-count restart (CTRL |= 0x8) at VALUE=2 with LOAD=7 -> VALUE=7 the next cycle; resetn pulsed low mid-count -> all registers, irq and irq_any read 0 immediately.
- Reads of addr 0x?0 for ch>=NUM_CH, and of offset 0xF8 -> rdata=0; writes there -> no state change in any channel.
